// File: rtl/fir_pkg.sv
// Shared types and constants for the heart-rate FIR low-pass filter.
//   state_t    : MAC engine states (IDLE, MAC, OUT)
//   COEFS31    : half coefficient table for the 31-tap symmetric filter;
//                entry 15 is the centre tap. All 31 taps sum to 1028
//                (unity gain is 1024).
//   acc_width  : accumulator width that cannot wrap for the given sizes
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int COEFS31_N = 16;

    localparam logic [7:0] COEFS31 [0:COEFS31_N-1] = '{
        8'd3,  8'd4,  8'd6,  8'd8,  8'd12, 8'd17, 8'd23, 8'd29,
        8'd36, 8'd43, 8'd50, 8'd56, 8'd61, 8'd65, 8'd67, 8'd68
    };

    // Pair sum is data_w+1 bits, times a coef_w coefficient, summed over
    // half terms.
    function automatic int acc_width(input int data_w, input int coef_w, input int half);
        return data_w + 1 + coef_w + $clog2(half);
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line for the FIR filter. x[0] is the newest sample.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset (clears line)
//   i_shift       : shift i_data in at x[0]
//   i_clear       : clear the whole line (takes priority over i_shift)
//   i_data        : sample to shift in
//   i_idx         : tap index k for the symmetric pair read
//   o_newest      : x[0]
//   o_lo, o_hi    : x[k] and x[NTAPS-1-k]
module fir_delay_line #(
    parameter int DATA_W = 10,
    parameter int NTAPS  = 31,
    parameter int IDX_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_shift,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [DATA_W-1:0] o_newest,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_hi
);

    logic [DATA_W-1:0] r_taps [NTAPS];
    logic [IDX_W-1:0]  w_hi_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) r_taps[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < NTAPS; i++) r_taps[i] <= '0;
        end else if (i_shift) begin
            r_taps[0] <= i_data;
            for (int i = 1; i < NTAPS; i++) r_taps[i] <= r_taps[i-1];
        end
    end

    assign w_hi_idx = IDX_W'(NTAPS - 1) - i_idx;
    assign o_newest = r_taps[0];
    assign o_lo     = r_taps[i_idx];
    assign o_hi     = r_taps[w_hi_idx];

endmodule

// File: rtl/fir_mac_filter.sv
// Symmetric low-pass FIR using one time-multiplexed multiply-accumulate.
// One accepted sample is processed in HALF MAC cycles plus one output cycle.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   in_valid   : sample present on in_data
//   in_data    : unsigned input sample
//   in_ready   : a sample is accepted on a clk edge with in_valid && in_ready
//   bypass     : pass the sample through unfiltered (captured at accept)
//   flush      : single-cycle pulse, clears the delay line while idle
//   out_valid  : one-cycle pulse, out_data holds a new result
//   out_data   : filtered sample, held until the next out_valid
//   busy       : MAC or output cycle in progress
// Handshake: in_ready is high only in IDLE with no flush and no reset; an
// in_valid seen while in_ready is low is dropped, never queued.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int DATA_W    = 10,
    parameter int NTAPS     = 31,
    parameter int COEF_W    = 8,
    parameter int FRAC_BITS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              bypass,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int HALF  = (NTAPS + 1) / 2;
    localparam int K_W   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int ACC_W = acc_width(DATA_W, COEF_W, HALF);

    localparam logic [ACC_W-1:0] ROUND   = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);
    localparam logic [K_W-1:0]   K_LAST  = K_W'(HALF - 1);

    state_t            r_state;
    logic [K_W-1:0]    r_k;
    logic [ACC_W-1:0]  r_acc;
    logic              r_bypass;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_clear;
    logic [DATA_W-1:0] w_newest;
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_hi;
    logic              w_is_centre;
    logic [DATA_W:0]   w_pair;
    logic [COEF_W-1:0] w_coef;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  w_rounded;
    logic [ACC_W-1:0]  w_scaled;
    logic [DATA_W-1:0] w_y;

    assign in_ready  = (r_state == IDLE) && !flush && !reset;
    assign w_accept  = in_valid && in_ready;
    // Flush wins over a simultaneous sample because in_ready excludes it.
    assign w_clear   = (r_state == IDLE) && flush && !reset;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    fir_delay_line #(
        .DATA_W (DATA_W),
        .NTAPS  (NTAPS),
        .IDX_W  (IDX_W)
    ) u_delay_line (
        .clk      (clk),
        .reset    (reset),
        .i_shift  (w_accept),
        .i_clear  (w_clear),
        .i_data   (in_data),
        .i_idx    (IDX_W'(r_k)),
        .o_newest (w_newest),
        .o_lo     (w_lo),
        .o_hi     (w_hi)
    );

    // Centre tap has no partner; every other step adds a symmetric pair.
    assign w_is_centre = (r_k == K_LAST);
    assign w_pair      = w_is_centre ? (DATA_W+1)'(w_lo)
                                     : (DATA_W+1)'(w_lo) + (DATA_W+1)'(w_hi);
    assign w_coef      = COEF_W'(COEFS31[r_k]);
    assign w_acc_next  = r_acc + ACC_W'(w_coef) * ACC_W'(w_pair);

    // Round half up, drop the coefficient scale, then clamp to full scale.
    assign w_rounded = w_acc_next + ROUND;
    assign w_scaled  = w_rounded >> FRAC_BITS;
    assign w_y       = (w_scaled > SAT_MAX) ? DATA_W'(SAT_MAX) : w_scaled[DATA_W-1:0];

    // The final MAC edge registers the result so out_valid is high for
    // exactly the one cycle spent in OUT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_acc       <= '0;
            r_bypass    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_k      <= '0;
                        r_bypass <= bypass;
                        r_state  <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    if (w_is_centre) begin
                        r_out_data  <= r_bypass ? w_newest : w_y;
                        r_out_valid <= 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                OUT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
module tb_fir_mac_filter;

    localparam int DATA_W    = 10;
    localparam int NTAPS     = 31;
    localparam int COEF_W    = 8;
    localparam int FRAC_BITS = 10;
    localparam int HALF      = (NTAPS + 1) / 2;
    localparam int LATENCY   = HALF + 1;

    localparam int COEF_HALF [16] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
    localparam int IMP_HALF  [16] = '{3, 4, 6, 8, 12, 17, 22, 28, 35, 42, 49, 55, 60, 63, 65, 66};

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              bypass;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    fir_mac_filter #(
        .DATA_W    (DATA_W),
        .NTAPS     (NTAPS),
        .COEF_W    (COEF_W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bypass    (bypass),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int m_cnt    = 0;
    bit run      = 0;

    logic [DATA_W-1:0] m_x [NTAPS];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_q [$];
    int                lat_q [$];
    logic [DATA_W-1:0] last_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Direct 31-tap convolution over the model delay line.
    function automatic logic [DATA_W-1:0] model_y();
        int unsigned s;
        s = 0;
        for (int t = 0; t < NTAPS; t++)
            s += COEF_HALF[(t < HALF) ? t : (NTAPS - 1 - t)] * m_x[t];
        s = (s + 512) >> FRAC_BITS;
        if (s > 1023) return 10'd1023;
        return s[DATA_W-1:0];
    endfunction

    function automatic int imp_exp(input int i);
        if (i < HALF)  return IMP_HALF[i];
        if (i < NTAPS) return IMP_HALF[NTAPS - 1 - i];
        return 0;
    endfunction

    // Model update on the active edge, DUT checks on the falling edge.
    always begin
        @(posedge clk);
        if (reset) begin
            for (int t = 0; t < NTAPS; t++) m_x[t] = '0;
            m_cnt = 0;
            exp_q.delete();
            lat_q.delete();
        end else if (m_cnt == 0) begin
            if (flush) begin
                for (int t = 0; t < NTAPS; t++) m_x[t] = '0;
            end else if (in_valid) begin
                for (int t = NTAPS - 1; t > 0; t--) m_x[t] = m_x[t-1];
                m_x[0] = in_data;
                exp_q.push_back(bypass ? in_data : model_y());
                lat_q.push_back(cyc);
                m_cnt = LATENCY;
                n_acc++;
            end
        end else begin
            m_cnt--;
        end
        cyc++;

        @(negedge clk);
        if (run) begin
            if (reset) last_out = '0;
            check("in_ready", 32'(in_ready), 32'(!reset && m_cnt == 0 && !flush));
            check("busy", 32'(busy), 32'(!reset && m_cnt != 0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    logic [DATA_W-1:0] e;
                    int                a;
                    e = exp_q.pop_front();
                    a = lat_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e));
                    check("latency", 32'(cyc - a), 32'(LATENCY));
                    last_out = e;
                    got_q.push_back(out_data);
                end
            end else begin
                check("out_hold", 32'(out_data), 32'(last_out));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DATA_W-1:0] d, input logic b);
        bit ok;
        int waited;
        ok = 0;
        waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        bypass   = b;
        while (!ok && waited < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        bypass   = 1'b0;
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_cnt != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        int n0;
        int prev;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        bypass   = 1'b0;
        flush    = 1'b0;

        // Reset asserted mid-cycle, held across two edges.
        #3;
        reset = 1'b1;
        run   = 1;
        @(negedge clk);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Impulse response on an empty line.
        base = got_q.size();
        send(10'd1000, 1'b0);
        repeat (32) send(10'd0, 1'b0);
        drain();
        check("impulse_count", 32'(got_q.size() - base), 32'd33);
        for (int i = 0; i < 33; i++)
            check($sformatf("impulse_%0d", i), 32'(got_q[base + i]), 32'(imp_exp(i)));

        // DC gain and saturation.
        repeat (40) send(10'd512, 1'b0);
        drain();
        check("dc_512", 32'(got_q[$]), 32'd514);
        repeat (40) send(10'd1023, 1'b0);
        drain();
        check("dc_1023_sat", 32'(got_q[$]), 32'd1023);

        // in_valid held high: one accept every HALF+2 cycles.
        n0 = n_acc;
        prev = n_acc;
        in_valid = 1'b1;
        in_data  = 10'd100;
        repeat (144) begin
            @(posedge clk);
            #1;
            if (n_acc != prev) begin
                in_data = in_data + 10'd1;
                prev = n_acc;
            end
        end
        in_valid = 1'b0;
        check("stream_accepts", 32'(n_acc - n0), 32'd8);
        drain();

        // Bypass: raw sample out with the same latency; line still shifts.
        send(10'd777, 1'b1);
        drain();
        check("bypass_777", 32'(got_q[$]), 32'd777);
        send(10'd0, 1'b0);
        drain();

        // Flush and in_valid together while idle: flush wins.
        n0 = n_acc;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 10'd555;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_rejects_sample", 32'(n_acc - n0), 32'd0);
        send(10'd1000, 1'b0);
        drain();
        check("flush_then_impulse", 32'(got_q[$]), 32'd3);

        // Reset five cycles after an accept aborts the sample.
        base = got_q.size();
        send(10'd1000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midmac_out_data", 32'(out_data), 32'd0);
        check("midmac_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midmac_no_output", 32'(got_q.size() - base), 32'd0);

        base = got_q.size();
        send(10'd1000, 1'b0);
        repeat (15) send(10'd0, 1'b0);
        drain();
        for (int i = 0; i < 16; i++)
            check($sformatf("impulse2_%0d", i), 32'(got_q[base + i]), 32'(imp_exp(i)));

        repeat (3) @(posedge clk);
        #1;
        run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
